// File: rtl/single_cycle_cpu.sv
// Single-cycle RV32I-subset core with internal IMEM/DMEM.
// Every datapath and control net is exported for stage-by-stage observation.
module single_cycle_cpu (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PCin,
  output logic [31:0] PC_to_IM,
  output logic [31:0] instruction,
  output logic [31:0] readData1,
  output logic [31:0] readData2,
  output logic [31:0] immval,
  output logic [31:0] ALUresult,
  output logic        branchctl,
  output logic [31:0] PC4,
  output logic [3:0]  ALUcntrl,
  output logic        zero,
  output logic [31:0] DataRead,
  output logic [31:0] DataWritten,
  output logic        memRead,
  output logic        regsrc,
  output logic [1:0]  ALUOp,
  output logic        memWrite,
  output logic        ALUSrc,
  output logic        regWrite,
  output logic [31:0] branchoff,
  output logic [31:0] branchval,
  output logic [31:0] ALUinB,
  output logic        ALUmsb,
  output logic [31:0] upperimm,
  output logic        branchselect,
  output logic [31:0] DataReadSized,
  output logic [31:0] PCin_final,
  output logic        jumpsrc,
  output logic        ALUsrc1,
  output logic [31:0] ALUinA
);

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_I      = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111,
    OP_JAL    = 7'b1101111,
    OP_JALR   = 7'b1100111
  } opcode_t;

  typedef enum logic [3:0] {
    ALU_AND  = 4'b0000,
    ALU_OR   = 4'b0001,
    ALU_ADD  = 4'b0010,
    ALU_XOR  = 4'b0011,
    ALU_SLL  = 4'b0100,
    ALU_SRL  = 4'b0101,
    ALU_SUB  = 4'b0110,
    ALU_SLT  = 4'b0111,
    ALU_SRA  = 4'b1000,
    ALU_SLTU = 4'b1001
  } alu_op_t;

  logic [31:0] imem [256];
  logic [31:0] dmem [256];
  logic [31:0] regs [32];

  opcode_t     opcode;
  alu_op_t     alu_sel;
  logic [2:0]  funct3;
  logic [4:0]  rs1, rs2, rd;
  logic        is_jal, is_lui;
  logic        sub_ovf, lt_signed, lt_unsigned, branch_cond;
  logic [3:0]  byte_en;
  logic [31:0] store_data;

  initial begin
    for (int unsigned i = 0; i < 256; i++) imem[i[7:0]] = 32'h0000_0013;
  end

  assign instruction = imem[PC_to_IM[9:2]];
  assign opcode      = opcode_t'(instruction[6:0]);
  assign funct3      = instruction[14:12];
  assign rs1         = instruction[19:15];
  assign rs2         = instruction[24:20];
  assign rd          = instruction[11:7];
  assign upperimm    = {instruction[31:12], 12'b0};

  always_comb begin
    branchctl = 1'b0;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    regWrite  = 1'b0;
    regsrc    = 1'b0;
    ALUSrc    = 1'b0;
    ALUsrc1   = 1'b0;
    jumpsrc   = 1'b0;
    ALUOp     = 2'b00;
    is_jal    = 1'b0;
    is_lui    = 1'b0;
    case (opcode)
      OP_R:      begin regWrite = 1'b1; ALUOp = 2'b10; end
      OP_I:      begin regWrite = 1'b1; ALUOp = 2'b11; ALUSrc = 1'b1; end
      OP_LOAD:   begin regWrite = 1'b1; memRead = 1'b1; regsrc = 1'b1; ALUSrc = 1'b1; end
      OP_STORE:  begin memWrite = 1'b1; ALUSrc = 1'b1; end
      OP_BRANCH: begin branchctl = 1'b1; ALUOp = 2'b01; end
      OP_LUI:    begin regWrite = 1'b1; ALUSrc = 1'b1; is_lui = 1'b1; end
      OP_AUIPC:  begin regWrite = 1'b1; ALUSrc = 1'b1; ALUsrc1 = 1'b1; end
      OP_JAL:    begin regWrite = 1'b1; is_jal = 1'b1; end
      OP_JALR:   begin regWrite = 1'b1; ALUSrc = 1'b1; jumpsrc = 1'b1; end
      default:   ;
    endcase
  end

  // B/J immediates are kept without their implicit zero LSB; branchoff restores it.
  always_comb begin
    case (opcode)
      OP_STORE:         immval = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
      OP_BRANCH:        immval = {{20{instruction[31]}}, instruction[31], instruction[7],
                                  instruction[30:25], instruction[11:8]};
      OP_JAL:           immval = {{12{instruction[31]}}, instruction[31], instruction[19:12],
                                  instruction[20], instruction[30:21]};
      OP_LUI, OP_AUIPC: immval = upperimm;
      default:          immval = {{20{instruction[31]}}, instruction[31:20]};
    endcase
  end

  always_comb begin
    alu_sel = ALU_ADD;
    case (ALUOp)
      2'b00: alu_sel = ALU_ADD;
      2'b01: alu_sel = ALU_SUB;
      default:
        case (funct3)
          3'b000:  alu_sel = (ALUOp == 2'b10 && instruction[30]) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_sel = ALU_SLL;
          3'b010:  alu_sel = ALU_SLT;
          3'b011:  alu_sel = ALU_SLTU;
          3'b100:  alu_sel = ALU_XOR;
          3'b101:  alu_sel = instruction[30] ? ALU_SRA : ALU_SRL;
          3'b110:  alu_sel = ALU_OR;
          default: alu_sel = ALU_AND;
        endcase
    endcase
  end
  assign ALUcntrl = alu_sel;

  assign readData1 = (rs1 == 5'd0) ? '0 : regs[rs1];
  assign readData2 = (rs2 == 5'd0) ? '0 : regs[rs2];
  assign ALUinA    = ALUsrc1 ? PC_to_IM : readData1;
  assign ALUinB    = ALUSrc ? immval : readData2;

  always_comb begin
    case (alu_sel)
      ALU_AND:  ALUresult = ALUinA & ALUinB;
      ALU_OR:   ALUresult = ALUinA | ALUinB;
      ALU_ADD:  ALUresult = ALUinA + ALUinB;
      ALU_SUB:  ALUresult = ALUinA - ALUinB;
      ALU_XOR:  ALUresult = ALUinA ^ ALUinB;
      ALU_SLL:  ALUresult = ALUinA << ALUinB[4:0];
      ALU_SRL:  ALUresult = ALUinA >> ALUinB[4:0];
      ALU_SRA:  ALUresult = 32'($signed(ALUinA) >>> ALUinB[4:0]);
      ALU_SLT:  ALUresult = {31'b0, $signed(ALUinA) < $signed(ALUinB)};
      ALU_SLTU: ALUresult = {31'b0, ALUinA < ALUinB};
      default:  ALUresult = '0;
    endcase
  end
  assign zero   = (ALUresult == '0);
  assign ALUmsb = ALUresult[31];

  assign sub_ovf     = (ALUinA[31] ^ ALUinB[31]) & (ALUresult[31] ^ ALUinA[31]);
  assign lt_signed   = ALUmsb ^ sub_ovf;
  assign lt_unsigned = readData1 < readData2;

  always_comb begin
    case (funct3)
      3'b000:  branch_cond = zero;
      3'b001:  branch_cond = ~zero;
      3'b100:  branch_cond = lt_signed;
      3'b101:  branch_cond = ~lt_signed;
      3'b110:  branch_cond = lt_unsigned;
      3'b111:  branch_cond = ~lt_unsigned;
      default: branch_cond = 1'b0;
    endcase
  end
  assign branchselect = branchctl & branch_cond;

  assign PC4        = PC_to_IM + 32'd4;
  assign branchoff  = immval << 1;
  assign branchval  = PC_to_IM + branchoff;
  assign PCin       = branchselect ? branchval : PC4;
  assign PCin_final = jumpsrc ? {ALUresult[31:1], 1'b0} : (is_jal ? branchval : PCin);

  assign DataRead = dmem[ALUresult[9:2]];

  always_comb begin
    case (funct3)
      3'b000:  DataReadSized = {{24{DataRead[{ALUresult[1:0], 3'b000} + 7]}},
                                DataRead[{ALUresult[1:0], 3'b000} +: 8]};
      3'b001:  DataReadSized = {{16{DataRead[{ALUresult[1], 4'b0000} + 15]}},
                                DataRead[{ALUresult[1], 4'b0000} +: 16]};
      3'b100:  DataReadSized = {24'b0, DataRead[{ALUresult[1:0], 3'b000} +: 8]};
      3'b101:  DataReadSized = {16'b0, DataRead[{ALUresult[1], 4'b0000} +: 16]};
      default: DataReadSized = DataRead;
    endcase
  end

  always_comb begin
    case (funct3[1:0])
      2'b00: begin
        byte_en    = 4'b0001 << ALUresult[1:0];
        store_data = {4{readData2[7:0]}};
      end
      2'b01: begin
        byte_en    = ALUresult[1] ? 4'b1100 : 4'b0011;
        store_data = {2{readData2[15:0]}};
      end
      default: begin
        byte_en    = 4'b1111;
        store_data = readData2;
      end
    endcase
  end

  always_comb begin
    if (is_jal || jumpsrc) DataWritten = PC4;
    else if (is_lui)       DataWritten = upperimm;
    else if (regsrc)       DataWritten = DataReadSized;
    else                   DataWritten = ALUresult;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PC_to_IM <= '0;
      for (int unsigned i = 0; i < 32; i++) regs[i[4:0]] <= '0;
    end else begin
      PC_to_IM <= PCin_final;
      if (regWrite && rd != 5'd0) regs[rd] <= DataWritten;
    end
  end

  // DMEM has no reset: contents survive rst, which only blocks the write.
  always_ff @(posedge clk) begin
    if (!rst && memWrite) begin
      if (byte_en[0]) dmem[ALUresult[9:2]][7:0]   <= store_data[7:0];
      if (byte_en[1]) dmem[ALUresult[9:2]][15:8]  <= store_data[15:8];
      if (byte_en[2]) dmem[ALUresult[9:2]][23:16] <= store_data[23:16];
      if (byte_en[3]) dmem[ALUresult[9:2]][31:24] <= store_data[31:24];
    end
  end

endmodule

// File: tb/tb_single_cycle_cpu.sv
// Directed-program bench for single_cycle_cpu; program is placed into IMEM
// through a hierarchical reference and each retired instruction is checked.
module tb_single_cycle_cpu;

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] PCin, PC_to_IM, instruction, readData1, readData2, immval, ALUresult;
   logic        branchctl;
   logic [31:0] PC4;
   logic [3:0]  ALUcntrl;
   logic        zero;
   logic [31:0] DataRead, DataWritten;
   logic        memRead, regsrc;
   logic [1:0]  ALUOp;
   logic        memWrite, ALUSrc, regWrite;
   logic [31:0] branchoff, branchval, ALUinB;
   logic        ALUmsb;
   logic [31:0] upperimm;
   logic        branchselect;
   logic [31:0] DataReadSized, PCin_final;
   logic        jumpsrc, ALUsrc1;
   logic [31:0] ALUinA;

   int unsigned checks = 0;
   int unsigned errors = 0;

   single_cycle_cpu dut (
      .clk(clk), .rst(rst), .PCin(PCin), .PC_to_IM(PC_to_IM), .instruction(instruction),
      .readData1(readData1), .readData2(readData2), .immval(immval), .ALUresult(ALUresult),
      .branchctl(branchctl), .PC4(PC4), .ALUcntrl(ALUcntrl), .zero(zero),
      .DataRead(DataRead), .DataWritten(DataWritten), .memRead(memRead), .regsrc(regsrc),
      .ALUOp(ALUOp), .memWrite(memWrite), .ALUSrc(ALUSrc), .regWrite(regWrite),
      .branchoff(branchoff), .branchval(branchval), .ALUinB(ALUinB), .ALUmsb(ALUmsb),
      .upperimm(upperimm), .branchselect(branchselect), .DataReadSized(DataReadSized),
      .PCin_final(PCin_final), .jumpsrc(jumpsrc), .ALUsrc1(ALUsrc1), .ALUinA(ALUinA)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic load(input logic [31:0] addr, input logic [31:0] word);
      dut.imem[addr[9:2]] = word;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      #1;
      load(32'h00, 32'h00500093);  // addi x1,x0,5
      load(32'h04, 32'hFFD00113);  // addi x2,x0,-3
      load(32'h08, 32'h002081B3);  // add  x3,x1,x2
      load(32'h0C, 32'h40208233);  // sub  x4,x1,x2
      load(32'h10, 32'h08000293);  // addi x5,x0,0x80
      load(32'h14, 32'h00502023);  // sw   x5,0(x0)
      load(32'h18, 32'h00000303);  // lb   x6,0(x0)
      load(32'h1C, 32'h00004383);  // lbu  x7,0(x0)
      load(32'h20, 32'h00108463);  // beq  x1,x1,+8
      load(32'h24, 32'h00100F93);  // addi x31,x0,1 (skipped)
      load(32'h28, 32'h00002403);  // lw   x8,0(x0)
      load(32'h2C, 32'h00109463);  // bne  x1,x1,+8
      load(32'h30, 32'h00114463);  // blt  x2,x1,+8
      load(32'h34, 32'h00100F93);  // addi x31,x0,1 (skipped)
      load(32'h38, 32'h00116463);  // bltu x2,x1,+8
      load(32'h3C, 32'h40115593);  // srai x11,x2,1
      load(32'h40, 32'h010000EF);  // jal  x1,+16
      load(32'h44, 32'h01C0006F);  // jal  x0,+28
      load(32'h50, 32'h00008067);  // jalr x0,0(x1)
      load(32'h60, 32'h123454B7);  // lui  x9,0x12345
      load(32'h64, 32'h00001517);  // auipc x10,1
      load(32'h68, 32'h00700013);  // addi x0,x0,7
      load(32'h6C, 32'h00112633);  // slt  x12,x2,x1
      load(32'h70, 32'h001136B3);  // sltu x13,x2,x1
      load(32'h74, 32'h00201123);  // sh   x2,2(x0)
      load(32'h78, 32'h00201703);  // lh   x14,2(x0)
      load(32'h7C, 32'h00205783);  // lhu  x15,2(x0)
      load(32'h80, 32'h00002803);  // lw   x16,0(x0)
      load(32'h84, 32'h001001A3);  // sb   x1,3(x0)
      load(32'h88, 32'h00002883);  // lw   x17,0(x0)
      load(32'h8C, 32'h0020C933);  // xor  x18,x1,x2
      load(32'h90, 32'hFFFFFFFF);  // unknown opcode
      step();
      step();
      rst = 1'b0;

      check("reset_pc", PC_to_IM, 32'h0);
      check("reset_instr", instruction, 32'h00500093);
      check("addi_wb", DataWritten, 32'h5);
      check("addi_next", PCin_final, 32'h4);

      step();
      check("pc_4", PC_to_IM, 32'h4);
      check("imm_neg", immval, 32'hFFFFFFFD);
      check("addi_neg_wb", DataWritten, 32'hFFFFFFFD);

      step();
      check("pc_8", PC_to_IM, 32'h8);
      check("add_rs1", readData1, 32'h5);
      check("add_rs2", readData2, 32'hFFFFFFFD);
      check("add_wb", DataWritten, 32'h2);

      step();
      check("pc_c", PC_to_IM, 32'hC);
      check("sub_ctl", 32'(ALUcntrl), 32'h6);
      check("sub_wb", DataWritten, 32'h8);

      step();
      check("addi80_wb", DataWritten, 32'h80);

      step();
      check("sw_memwrite", 32'(memWrite), 32'h1);
      check("sw_regwrite", 32'(regWrite), 32'h0);
      check("sw_data", readData2, 32'h80);

      step();
      check("lb_raw", DataRead, 32'h00000080);
      check("lb_wb", DataWritten, 32'hFFFFFF80);

      step();
      check("lbu_wb", DataWritten, 32'h00000080);

      step();
      check("pc_20", PC_to_IM, 32'h20);
      check("beq_ctl", 32'(branchctl), 32'h1);
      check("beq_off", branchoff, 32'h8);
      check("beq_sel", 32'(branchselect), 32'h1);
      check("beq_pcin", PCin, 32'h28);
      check("beq_next", PCin_final, 32'h28);

      step();
      check("pc_28", PC_to_IM, 32'h28);
      check("lw_wb", DataWritten, 32'h80);

      step();
      check("bne_sel", 32'(branchselect), 32'h0);
      check("bne_next", PCin_final, 32'h30);

      step();
      check("blt_sel", 32'(branchselect), 32'h1);
      check("blt_next", PCin_final, 32'h38);

      step();
      check("bltu_sel", 32'(branchselect), 32'h0);
      check("bltu_next", PCin_final, 32'h3C);

      step();
      check("srai_ctl", 32'(ALUcntrl), 32'h8);
      check("srai_wb", DataWritten, 32'hFFFFFFFE);

      step();
      check("pc_40", PC_to_IM, 32'h40);
      check("jal_link", DataWritten, 32'h44);
      check("jal_next", PCin_final, 32'h50);

      step();
      check("pc_50", PC_to_IM, 32'h50);
      check("jalr_rs1", readData1, 32'h44);
      check("jalr_src", 32'(jumpsrc), 32'h1);
      check("jalr_next", PCin_final, 32'h44);

      step();
      check("pc_44", PC_to_IM, 32'h44);
      check("jal_fwd_next", PCin_final, 32'h60);

      step();
      check("lui_wb", DataWritten, 32'h12345000);

      step();
      check("auipc_src", 32'(ALUsrc1), 32'h1);
      check("auipc_wb", DataWritten, 32'h00001064);

      step();
      check("pc_68", PC_to_IM, 32'h68);

      step();
      check("slt_wb", DataWritten, 32'h1);

      step();
      check("sltu_wb", DataWritten, 32'h0);

      step();
      check("sh_memwrite", 32'(memWrite), 32'h1);

      step();
      check("lh_wb", DataWritten, 32'hFFFFFFFD);

      step();
      check("lhu_wb", DataWritten, 32'h0000FFFD);

      step();
      check("lw_half_wb", DataWritten, 32'hFFFD0080);

      step();
      check("sb_data", readData2, 32'h44);

      step();
      check("lw_byte_wb", DataWritten, 32'h44FD0080);

      step();
      check("xor_wb", DataWritten, 32'hFFFFFFB9);

      step();
      check("unk_regwrite", 32'(regWrite), 32'h0);
      check("unk_memwrite", 32'(memWrite), 32'h0);
      check("unk_next", PCin_final, 32'h94);

      step();
      check("pc_94", PC_to_IM, 32'h94);
      check("nop_fill", instruction, 32'h00000013);

      load(32'h00, 32'h00018A33);  // add  x20,x3,x0
      load(32'h04, 32'h00700013);  // addi x0,x0,7
      load(32'h08, 32'h00000AB3);  // add  x21,x0,x0
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_pc", PC_to_IM, 32'h0);
      check("midrst_instr", instruction, 32'h00018A33);
      check("midrst_x3", readData1, 32'h0);

      step();
      check("x0w_pc", PC_to_IM, 32'h4);
      check("x0w_wb", DataWritten, 32'h7);

      step();
      check("x0_read", readData1, 32'h0);
      check("x0_wb", DataWritten, 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
